// File: rtl/shift_rotate_unit_if.sv
// Handshake and operand/result bundle for shift_rotate_unit.
// The zero/cout flag signals exist only when SHIFT_FLAGS_EN is defined.
interface shift_rotate_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [4:0]       operation;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] result;
    logic             busy;
    logic             done;
    logic             err;
`ifdef SHIFT_FLAGS_EN
    logic             zero;
    logic             cout;
`endif

    modport master (
        output start, operation, A, B,
        input  result, busy, done, err
`ifdef SHIFT_FLAGS_EN
        , input zero, cout
`endif
    );

    modport slave (
        input  start, operation, A, B,
        output result, busy, done, err
`ifdef SHIFT_FLAGS_EN
        , output zero, cout
`endif
    );
endinterface

// File: rtl/shift_rotate_unit.sv
// Multi-cycle SHR/SHRA/SHL/ROR/ROL unit, up to STEP bits per busy cycle.
// Optional zero/cout result flags are built when SHIFT_FLAGS_EN is defined.
module shift_rotate_unit #(
    parameter int WIDTH = 32,
    parameter int STEP  = 4
) (
    input  logic           Clock,
    input  logic           Resetn,
    shift_rotate_unit_if.slave bus
);
    localparam int AW = $clog2(WIDTH);

    localparam logic [AW-1:0] STEP_W = AW'(STEP);
    localparam logic [AW:0]   WIDTH_W = (AW+1)'(WIDTH);

    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHRA = 5'b01010;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_ROR  = 5'b01100;
    localparam logic [4:0] OP_ROL  = 5'b01101;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]       state_q,  state_d;
    logic [WIDTH-1:0] acc_q,    acc_d;
    logic [AW-1:0]    rem_q,    rem_d;
    logic [4:0]       op_q,     op_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             done_q,   done_d;
    logic             err_q,    err_d;
`ifdef SHIFT_FLAGS_EN
    logic             cflag_q,  cflag_d;
    logic             zero_q,   zero_d;
    logic             cout_q,   cout_d;
    logic             step_out;
`endif

    logic             op_legal;
    logic [AW-1:0]    step_amt;
    logic [AW:0]      inv_amt;
    logic [WIDTH-1:0] shifted;
    logic             unused_b;

    assign unused_b = ^bus.B[WIDTH-1:AW];

    assign op_legal = (op_q == OP_SHR) || (op_q == OP_SHRA) || (op_q == OP_SHL) ||
                      (op_q == OP_ROR) || (op_q == OP_ROL);

    // Per-cycle distance is min(STEP, rem); inv_amt is the complementary
    // distance used for the wrap-around half of the rotates.
    assign step_amt = (rem_q > STEP_W) ? STEP_W : rem_q;
    assign inv_amt  = WIDTH_W - {1'b0, step_amt};

    always_comb begin
        shifted = acc_q;
        case (op_q)
            OP_SHR:  shifted = acc_q >> step_amt;
            OP_SHRA: shifted = $unsigned($signed(acc_q) >>> step_amt);
            OP_SHL:  shifted = acc_q << step_amt;
            OP_ROR:  shifted = (acc_q >> step_amt) | (acc_q << inv_amt);
            OP_ROL:  shifted = (acc_q << step_amt) | (acc_q >> inv_amt);
            default: shifted = acc_q;
        endcase
    end

`ifdef SHIFT_FLAGS_EN
    // Right-going ops lose acc[s-1] last; left-going ops lose acc[WIDTH-s].
    always_comb begin
        step_out = 1'b0;
        case (op_q)
            OP_SHR, OP_SHRA, OP_ROR: step_out = acc_q[step_amt - 1'b1];
            OP_SHL, OP_ROL:          step_out = acc_q[inv_amt[AW-1:0]];
            default:                 step_out = 1'b0;
        endcase
    end
`endif

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        op_d     = op_q;
        result_d = result_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
`ifdef SHIFT_FLAGS_EN
        cflag_d  = cflag_q;
        zero_d   = zero_q;
        cout_d   = cout_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    acc_d   = bus.A;
                    rem_d   = bus.B[AW-1:0];
                    op_d    = bus.operation;
                    state_d = ST_SHIFT;
`ifdef SHIFT_FLAGS_EN
                    cflag_d = 1'b0;
`endif
                end
            end
            ST_SHIFT: begin
                if ((rem_q == '0) || !op_legal) begin
                    result_d = acc_q;
                    done_d   = 1'b1;
                    err_d    = !op_legal;
                    state_d  = ST_DONE;
`ifdef SHIFT_FLAGS_EN
                    zero_d   = (acc_q == '0);
                    cout_d   = op_legal & cflag_q;
`endif
                end else begin
                    acc_d = shifted;
                    rem_d = rem_q - step_amt;
`ifdef SHIFT_FLAGS_EN
                    cflag_d = step_out;
`endif
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q  <= ST_IDLE;
            acc_q    <= '0;
            rem_q    <= '0;
            op_q     <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
`ifdef SHIFT_FLAGS_EN
            cflag_q  <= 1'b0;
            zero_q   <= 1'b0;
            cout_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            op_q     <= op_d;
            result_q <= result_d;
            done_q   <= done_d;
            err_q    <= err_d;
`ifdef SHIFT_FLAGS_EN
            cflag_q  <= cflag_d;
            zero_q   <= zero_d;
            cout_q   <= cout_d;
`endif
        end
    end

    assign bus.result = result_q;
    assign bus.busy   = (state_q != ST_IDLE);
    assign bus.done   = done_q;
    assign bus.err    = err_q;
`ifdef SHIFT_FLAGS_EN
    assign bus.zero   = zero_q;
    assign bus.cout   = cout_q;
`endif
endmodule
